// File: rtl/keypad_digit_fifo.sv
// keypad_digit_fifo
//
// Front end for the lock CPU's parallel-input port. It debounces an active-low
// "enter" pushbutton and captures the BCD digit on the switches on each
// accepted press. Captured digits are queued in a small FIFO. The head digit
// and the queue status are presented as one byte for the CPU to read, and each
// CPU read strobe pops one digit. A second debounced "clear" pushbutton
// flushes the queue and clears the sticky error flags.
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active-high
//   key_n     enter pushbutton, active-low, asynchronous, bouncy
//   clr_n     clear pushbutton, active-low, asynchronous, bouncy
//   digit     BCD digit from the switches, sampled on the accepted press
//   rd_en     one-cycle pop strobe from the CPU read of the input address
//   data_out  {nonempty, count[2:0], head_digit[3:0]}
//   full      the queue holds DEPTH digits
//   err       sticky: a press occurred with digit > 9
//   ovf       sticky: a press occurred while full with no simultaneous pop

module keypad_digit_fifo #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DEPTH           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic       clr_n,
  input  logic [3:0] digit,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       full,
  output logic       err,
  output logic       ovf
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       CNT_DEPTH = 3'(DEPTH);

  // Two-flop synchronisers
  logic key_sync_p0, key_sync_p1;
  logic clr_sync_p0, clr_sync_p1;

  // Debounced key levels and their stability counters
  logic             key_db, clr_db;
  logic [CNT_W-1:0] key_cnt, clr_cnt;

  // FIFO state
  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [2:0]       count;

  // Combinational control
  logic key_mis, clr_mis;
  logic key_acc, clr_acc;
  logic enter_press, clr_press;
  logic nonempty, is_full, digit_bad;
  logic do_push, do_pop, ovf_set;
  logic [3:0] head;

  // ---- stage p0/p1: synchronise the asynchronous pushbuttons ----
  always_ff @(posedge clk) begin
    if (rst) begin
      key_sync_p0 <= 1'b1;
      key_sync_p1 <= 1'b1;
      clr_sync_p0 <= 1'b1;
      clr_sync_p1 <= 1'b1;
    end else begin
      key_sync_p0 <= key_n;
      key_sync_p1 <= key_sync_p0;
      clr_sync_p0 <= clr_n;
      clr_sync_p1 <= clr_sync_p0;
    end
  end

  // A level is accepted on the edge where the counter has already seen
  // DEBOUNCE_CYCLES-1 mismatching cycles and the mismatch is still present.
  // A press is a 1->0 acceptance, so it acts on the same edge the debounced
  // state changes.
  always_comb begin
    key_mis     = (key_sync_p1 != key_db);
    clr_mis     = (clr_sync_p1 != clr_db);
    key_acc     = key_mis && (key_cnt == CNT_LAST);
    clr_acc     = clr_mis && (clr_cnt == CNT_LAST);
    enter_press = key_acc && !key_sync_p1;
    clr_press   = clr_acc && !clr_sync_p1;
  end

  // ---- stage debounce: per-key stability counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      key_db  <= 1'b1;
      clr_db  <= 1'b1;
      key_cnt <= '0;
      clr_cnt <= '0;
    end else begin
      if (!key_mis) begin
        key_cnt <= '0;
      end else if (key_acc) begin
        key_db  <= key_sync_p1;
        key_cnt <= '0;
      end else begin
        key_cnt <= key_cnt + CNT_W'(1);
      end

      if (!clr_mis) begin
        clr_cnt <= '0;
      end else if (clr_acc) begin
        clr_db  <= clr_sync_p1;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + CNT_W'(1);
      end
    end
  end

  // When full, a same-cycle pop frees the slot the push needs, so the push is
  // accepted. The write lands at wr_ptr, which equals the old rd_ptr, and that
  // slot becomes the new tail.
  always_comb begin
    nonempty  = (count != 3'd0);
    is_full   = (count == CNT_DEPTH);
    digit_bad = (digit > 4'd9);
    do_pop    = rd_en && nonempty;
    do_push   = enter_press && !digit_bad && (!is_full || rd_en);
    ovf_set   = enter_press && !digit_bad && is_full && !rd_en;
  end

  // ---- stage fifo: pointers, count and sticky flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 3'd0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else if (clr_press) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 3'd0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (enter_press && digit_bad) err <= 1'b1;
      if (ovf_set)                  ovf <= 1'b1;
    end
  end

  // Storage is data only; occupancy is tracked by the control registers, so
  // the entries need no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clr_press && !rst) mem[wr_ptr] <= digit;
  end

  // ---- output decode from registered state ----
  always_comb begin
    head     = nonempty ? mem[rd_ptr] : 4'd0;
    data_out = {nonempty, count, head};
    full     = is_full;
  end

endmodule

// File: tb/tb_keypad_digit_fifo.sv
// Directed testbench for keypad_digit_fifo, run with DEBOUNCE_CYCLES = 4 and
// DEPTH = 4. Inputs change 1 time unit after a rising edge. Outputs are
// sampled 1 time unit after the edge that is expected to update them.

module tb_keypad_digit_fifo;

  logic       clk;
  logic       rst;
  logic       key_n;
  logic       clr_n;
  logic [3:0] digit;
  logic       rd_en;
  logic [7:0] data_out;
  logic       full;
  logic       err;
  logic       ovf;

  int checks;
  int errors;

  keypad_digit_fifo #(
    .DEBOUNCE_CYCLES(4),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .clr_n(clr_n),
    .digit(digit),
    .rd_en(rd_en),
    .data_out(data_out),
    .full(full),
    .err(err),
    .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enter press with digit d. The press is accepted on the 6th edge after
  // key_n goes low, and pop drives rd_en on exactly that edge.
  // The key is then held released long enough to debounce back to 1.
  task automatic press(input logic [3:0] d, input logic pop);
    digit = d;
    key_n = 1'b0;
    repeat (5) tick();
    rd_en = pop;
    tick();
    rd_en = 1'b0;
    key_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic press_clear();
    clr_n = 1'b0;
    repeat (6) tick();
    clr_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic pop_once();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    key_n = 1'b0;
    clr_n = 1'b1;
    digit = 4'd5;
    rd_en = 1'b0;
    tick();
    tick();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_out got %h want %h", data_out, 8'h00);
    end
    checks++;
    if ({full, err, ovf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want %b", {full, err, ovf}, 3'b000);
    end
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_early_press got %h want %h", data_out, 8'h00);
    end
    tick();
    checks++;
    if (data_out !== 8'h95) begin
      errors++;
      $display("FAIL reset_press_6_edges got %h want %h", data_out, 8'h95);
    end
    key_n = 1'b1;
    repeat (6) tick();
    pop_once();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_drain got %h want %h", data_out, 8'h00);
    end
  endtask

  task automatic test_push_pop();
    press(4'd3, 1'b0);
    checks++;
    if (data_out !== 8'h93) begin
      errors++;
      $display("FAIL push3 got %h want %h", data_out, 8'h93);
    end
    press(4'd7, 1'b0);
    checks++;
    if (data_out !== 8'hA3) begin
      errors++;
      $display("FAIL push7 got %h want %h", data_out, 8'hA3);
    end
    pop_once();
    checks++;
    if (data_out !== 8'h97) begin
      errors++;
      $display("FAIL pop1 got %h want %h", data_out, 8'h97);
    end
    pop_once();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL pop2 got %h want %h", data_out, 8'h00);
    end
    for (int i = 0; i < 2; i++) begin
      pop_once();
      checks++;
      if (data_out !== 8'h00) begin
        errors++;
        $display("FAIL pop_empty%0d got %h want %h", i, data_out, 8'h00);
      end
    end
  endtask

  task automatic test_bounce();
    digit = 4'd6;
    key_n = 1'b0;
    repeat (3) tick();
    key_n = 1'b1;
    tick();
    key_n = 1'b0;
    repeat (3) tick();
    key_n = 1'b1;
    repeat (8) tick();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL bounce_rejected got %h want %h", data_out, 8'h00);
    end
    key_n = 1'b0;
    repeat (10) tick();
    key_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (data_out !== 8'h96) begin
      errors++;
      $display("FAIL bounce_hold_one_push got %h want %h", data_out, 8'h96);
    end
    pop_once();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL bounce_drain got %h want %h", data_out, 8'h00);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) press(4'(i), 1'b0);
    checks++;
    if (data_out !== 8'hC1) begin
      errors++;
      $display("FAIL ovf_data_out got %h want %h", data_out, 8'hC1);
    end
    checks++;
    if ({full, ovf, err} !== 3'b110) begin
      errors++;
      $display("FAIL ovf_flags got %b want %b", {full, ovf, err}, 3'b110);
    end
    press_clear();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL clear_data_out got %h want %h", data_out, 8'h00);
    end
    checks++;
    if ({full, ovf} !== 2'b00) begin
      errors++;
      $display("FAIL clear_flags got %b want %b", {full, ovf}, 2'b00);
    end
  endtask

  task automatic test_full_with_pop();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'hB3;
    exp_seq[1] = 8'hA4;
    exp_seq[2] = 8'h99;
    exp_seq[3] = 8'h00;
    for (int i = 1; i <= 4; i++) press(4'(i), 1'b0);
    checks++;
    if ({data_out, full} !== {8'hC1, 1'b1}) begin
      errors++;
      $display("FAIL full_fill got %h/%b want %h/1", data_out, full, 8'hC1);
    end
    press(4'd9, 1'b1);
    checks++;
    if (data_out !== 8'hC2) begin
      errors++;
      $display("FAIL full_pop_push got %h want %h", data_out, 8'hC2);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_no_ovf got %b want %b", ovf, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      pop_once();
      checks++;
      if (data_out !== exp_seq[i]) begin
        errors++;
        $display("FAIL full_drain%0d got %h want %h", i, data_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_invalid_digit();
    press(4'd5, 1'b0);
    press(4'hA, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL bad_digit_err got %b want %b", err, 1'b1);
    end
    checks++;
    if (data_out !== 8'h95) begin
      errors++;
      $display("FAIL bad_digit_no_push got %h want %h", data_out, 8'h95);
    end
    // Clear and enter are accepted on the same edge; clear wins.
    digit = 4'd2;
    key_n = 1'b0;
    clr_n = 1'b0;
    repeat (6) tick();
    key_n = 1'b1;
    clr_n = 1'b1;
    repeat (6) tick();
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL clear_vs_enter got %h want %h", data_out, 8'h00);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL clear_err got %b want %b", err, 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_push_pop();
    test_bounce();
    test_overflow();
    test_full_with_pop();
    test_invalid_digit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
